unison_readout_packer: RTL and testbench
========================================

Name: unison_readout_packer

Overview:
- Downstream consumer of one digital_unison instance.
- Samples the 2-bit I and 2-bit Q readout streams on every enabled clk_master edge and packs 8 consecutive 4-bit samples into a 32-bit word.
- Tags each word with an 8-bit sequence number and buffers it in a small show-ahead FIFO.
- A host-side reader (logic analyzer / CSR bridge) pops words over a valid/ready handshake. Overflow and dropped-word counts are exposed for diagnostics.

Parameters:
DEPTH, 8, FIFO depth in words; power of two, 2..32.
LEVEL_W, $clog2(DEPTH)+1, width of fill-level output.

Ports:
clk_master  input  1  sole clock; same master clock that drives the paired digital_unison.
rstb  input  1  asynchronous active-low reset.
cap_en  input  1  capture enable, driven from ud_en.
clear  input  1  synchronous flush of FIFO, partial word, flags and counters.
read_out_I  input  2  I readout from digital_unison.
read_out_Q  input  2  Q readout from digital_unison.
rd_data  output  32  head-of-FIFO packed word.
rd_seq  output  8  sequence tag of head word.
rd_valid  output  1  head word valid.
rd_ready  input  1  reader accepts head word.
level  output  LEVEL_W  number of stored words.
overflow  output  1  sticky: a completed word was dropped.
drop_cnt  output  8  saturating count of dropped words.

Behaviour:
- Interface (already decided): one clock, clk_master; reset rstb is asynchronous and active-low. No other clock domain exists inside this block; any CDC to the Wishbone clock lives outside it.
- Reset values: rd_data=0, rd_seq=0, rd_valid=0, level=0, overflow=0, drop_cnt=0. Internal sample index, partial word, seq counter, and FIFO pointers are also 0.
- Reset asserted mid-word or mid-pop discards everything immediately, including the partial word.
- Sample format: sample = {read_out_I[1:0], read_out_Q[1:0]}. Sample k of a word (k=0 oldest) occupies bits [4k+3:4k].
- Capture: on each rising clk_master edge with cap_en=1, the sample is written at index k and k increments.
  - At k=7 the word completes on that same edge, including the current sample. It is pushed to the FIFO with tag = seq counter, seq increments, and k returns to 0.
  - cap_en=0 holds k and the partial word. Capture resumes at the same index; there is no re-alignment.
- Seq counter: increments on every completed word, whether stored or dropped, and wraps 255->0. The reader detects gaps from the tag.
- FIFO is show-ahead. rd_data/rd_seq/rd_valid are registered from the head entry.
  - Latency: a word completed while the FIFO is empty drives rd_valid=1 on the edge after the 8th sample, i.e. 1 cycle after completion.
  - Pop occurs when rd_valid & rd_ready at an edge. The next entry (or rd_valid=0 if empty) appears the following cycle.
  - rd_data and rd_seq are stable while rd_valid=1 and rd_ready=0.
- Full: a completed word while level==DEPTH and no pop that edge is dropped. overflow is set (sticky) and drop_cnt increments, saturating at 255.
  - Push and pop on the same edge when full: both occur, no drop, level unchanged.
- Empty: rd_ready is ignored when rd_valid=0. level never underflows.
- level: updated the same edge as push/pop (+1, -1, or unchanged when both or neither).
- clear (synchronous, highest priority):
  - Next state is the reset state except clk/reset behaviour.
  - The sample on a clear edge is not captured, and a pop on a clear edge is discarded.
- No combinational path from any input to any output.

Decomposition:
- Package unison_readout_pkg holds:
  - SAMPLE_W=4, SAMPLES_PER_WORD=8, WORD_W=32, SEQ_W=8, DROP_W=8.
  - Packed struct readout_entry_t {seq[7:0], data[31:0]}, 40 bits.
- Sub-module unison_sync_fifo, a single-clock show-ahead FIFO parameterised on width/depth with push, pop, full, empty and level. It holds readout_entry_t.
- The packer/counter logic stays in unison_readout_packer.

Test Plan:
- Reset then cap_en=1 with I=2'b10, Q=2'b01 constant for 8 cycles -> rd_data=32'h99999999, rd_seq=0, rd_valid=1 one cycle after the 8th edge, level=1.
- Sample values k=0..7 driving {I,Q}=k, with cap_en low for 3 cycles between k=3 and k=4, rd_ready=0 -> rd_data=32'h76543210, rd_seq=0. The hold does not shift alignment.
- DEPTH=8, rd_ready=0, 80 samples (10 words) -> level=8, overflow=1, drop_cnt=2. After draining: seqs 0..7 in order. The next stored word has seq=10.
- Fill to full, then assert rd_ready on the edge where word 9 completes -> no drop, overflow=0, level stays 8. The popped head was seq 0; the tail is seq 8.
- clear asserted after 5 samples with 3 words stored -> next cycle level=0, rd_valid=0, overflow=0. The following 8 samples produce seq=0 with sample 0 at bits [3:0].
- Assert rstb low asynchronously mid-pop with rd_valid=1 -> all outputs 0 before the next clock edge. After release, packing restarts at k=0.

Source files
------------

// File: rtl/unison_readout_pkg.sv
// unison_readout_pkg
// Shared constants and types for the digital_unison readout packer.
// A readout sample is {I[1:0], Q[1:0]}. Eight samples form one 32-bit word.
// Each word carries an 8-bit sequence tag so the reader can detect gaps.
package unison_readout_pkg;

    localparam int SAMPLE_W         = 4;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int WORD_W           = 32;
    localparam int SEQ_W            = 8;
    localparam int DROP_W           = 8;
    localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);

    // One FIFO entry; the tag occupies the upper 8 bits of the 40-bit vector
    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [WORD_W-1:0] data;
    } readout_entry_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/unison_readout_packer_fifo.sv
// unison_sync_fifo
// Single-clock show-ahead FIFO with a registered head.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          synchronous flush, wins over push and pop
//   push/push_data write an entry (accepted when not full, or full with a pop)
//   pop            remove the head (ignored unless head_valid)
//   head_data      registered copy of the oldest entry
//   head_valid     head_data holds a stored entry
//   full, empty    derived from the stored-entry count
//   level          number of stored entries
// An entry becomes visible on head_data one cycle after it is written.
module unison_sync_fifo #(
    parameter int WIDTH   = 40,
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic               head_valid,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic               head_valid_q, head_valid_d;
    logic [LEVEL_W-1:0] remain;
    logic               pop_ok;
    logic               push_ok;

    assign full       = (count_q == LEVEL_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign pop_ok     = pop && head_valid_q;
    assign push_ok    = push && (!full || pop_ok);
    assign head_data  = head_q;
    assign head_valid = head_valid_q;
    assign level      = count_q;

    // The head register is reloaded from entries that were already stored
    // before this edge (after removing a popped one). An entry written on this
    // edge can never be the next head, which gives the one-cycle visibility.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        remain       = count_q;
        head_valid_d = 1'b0;
        head_d       = '0;
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            remain   = count_q - LEVEL_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d = remain + LEVEL_W'(push_ok);
        if (remain != '0) begin
            head_valid_d = 1'b1;
            head_d       = mem_q[rd_ptr_d];
        end
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
            head_d       = '0;
        end
    end

    // Control and head state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/unison_readout_packer.sv
// unison_readout_packer
// Packs the 2-bit I/Q readout of one digital_unison into tagged 32-bit words
// and buffers them for a host-side reader.
// Ports:
//   clk_master             master clock shared with digital_unison
//   rstb                   asynchronous active-low reset
//   cap_en                 capture enable (from ud_en)
//   clear                  synchronous flush of everything
//   read_out_I/read_out_Q  readout streams; sample = {I, Q}
//   rd_data/rd_seq         head word and its sequence tag (registered)
//   rd_valid/rd_ready      reader handshake
//   level                  stored word count
//   overflow               sticky, a completed word was dropped
//   drop_cnt               saturating count of dropped words
module unison_readout_packer
    import unison_readout_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk_master,
    input  logic               rstb,
    input  logic               cap_en,
    input  logic               clear,
    input  logic [1:0]         read_out_I,
    input  logic [1:0]         read_out_Q,
    output logic [WORD_W-1:0]  rd_data,
    output logic [SEQ_W-1:0]   rd_seq,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt
);

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   partial_q, partial_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [SAMPLE_W-1:0] sample;
    logic [WORD_W-1:0]   word_filled;
    logic                word_done;
    logic                word_drop;
    logic                pop_ok;
    logic                fifo_full;
    logic                fifo_empty;
    readout_entry_t      push_entry;
    readout_entry_t      head_entry;

    assign sample   = {read_out_I, read_out_Q};
    assign pop_ok   = rd_valid && rd_ready && !fifo_empty;
    assign rd_data  = head_entry.data;
    assign rd_seq   = head_entry.seq;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // word_filled is the partial word with the current sample merged in, so a
    // completing word already contains its 8th sample. A word is dropped only
    // when the FIFO is full and no pop frees a slot on the same edge; the
    // sequence tag advances either way so the reader can see the gap.
    always_comb begin
        word_filled = partial_q;
        word_filled[int'(idx_q) * SAMPLE_W +: SAMPLE_W] = sample;
        word_done       = cap_en && (idx_q == IDX_W'(SAMPLES_PER_WORD - 1));
        word_drop       = word_done && fifo_full && !pop_ok;
        push_entry.seq  = seq_q;
        push_entry.data = word_filled;

        idx_d      = idx_q;
        partial_d  = partial_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (cap_en) begin
            if (word_done) begin
                idx_d     = '0;
                partial_d = '0;
                seq_d     = seq_q + SEQ_W'(1);
            end else begin
                idx_d     = idx_q + IDX_W'(1);
                partial_d = word_filled;
            end
        end
        if (word_drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
        if (clear) begin
            idx_d      = '0;
            partial_d  = '0;
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Packer and diagnostic state
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            idx_q      <= '0;
            partial_q  <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            partial_q  <= partial_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    unison_sync_fifo #(
        .WIDTH   ($bits(readout_entry_t)),
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk        (clk_master),
        .rst_n      (rstb),
        .clear      (clear),
        .push       (word_done && !clear),
        .push_data  (push_entry),
        .pop        (pop_ok),
        .head_data  (head_entry),
        .head_valid (rd_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (level)
    );

endmodule

// File: tb/tb_unison_readout_packer.sv
// tb_unison_readout_packer
// Scoreboard bench: a reference model predicts stored words into a queue and
// the expected status outputs; a monitor compares on every cycle and pops the
// queue whenever the DUT hands over a word.
module tb_unison_readout_packer;

    localparam int DEPTH   = 8;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               clk_master = 1'b0;
    logic               rstb       = 1'b0;
    logic               cap_en     = 1'b0;
    logic               clear      = 1'b0;
    logic               rd_ready   = 1'b0;
    logic [1:0]         read_out_I = 2'b00;
    logic [1:0]         read_out_Q = 2'b00;
    logic [31:0]        rd_data;
    logic [7:0]         rd_seq;
    logic               rd_valid;
    logic [LEVEL_W-1:0] level;
    logic               overflow;
    logic [7:0]         drop_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: words the model says are stored, oldest first
    logic [39:0] sb_q[$];
    int          m_k     = 0;
    logic [31:0] m_word  = '0;
    logic [7:0]  m_seq   = '0;
    int          m_count = 0;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;
    int          m_drops = 0;
    logic [39:0] head_exp;

    unison_readout_packer #(
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .cap_en     (cap_en),
        .clear      (clear),
        .read_out_I (read_out_I),
        .read_out_Q (read_out_Q),
        .rd_data    (rd_data),
        .rd_seq     (rd_seq),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk_master = ~clk_master;

    task automatic checkOutput(input string name, input logic [39:0] actual,
                               input logic [39:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and return 2 time units after the edge that used them
    task automatic applyStimulus(input logic cap, input logic [1:0] i_val,
                                 input logic [1:0] q_val, input logic rdy,
                                 input logic clr);
        cap_en     = cap;
        read_out_I = i_val;
        read_out_Q = q_val;
        rd_ready   = rdy;
        clear      = clr;
        @(posedge clk_master);
        #2;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_k     = 0;
        m_word  = '0;
        m_seq   = '0;
        m_count = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock edge of behaviour, using the inputs that were present at it
    task automatic model_step();
        int   old_count;
        logic pop;
        pop       = m_valid && rd_ready;
        old_count = m_count;
        if (clear) begin
            model_reset();
        end else begin
            if (pop) m_count--;
            if (cap_en) begin
                m_word = m_word + (32'({read_out_I, read_out_Q}) << (4 * m_k));
                if (m_k == 7) begin
                    if (old_count == DEPTH && !pop) begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end else begin
                        sb_q.push_back({m_seq, m_word});
                        m_count++;
                    end
                    m_seq  = m_seq + 8'd1;
                    m_k    = 0;
                    m_word = '0;
                end else begin
                    m_k++;
                end
            end
            m_valid = (old_count - (pop ? 1 : 0)) > 0;
        end
    endtask

    always @(negedge rstb) model_reset();

    always @(posedge clk_master) begin
        #1;
        if (rstb) model_step();
    end

    // Monitor: compare status every cycle, and the head word whenever it is presented
    always @(negedge clk_master) begin
        if (rstb) begin
            checkOutput("mon_valid", rd_valid, m_valid);
            checkOutput("mon_level", level, m_count);
            checkOutput("mon_overflow", overflow, m_ovf);
            checkOutput("mon_drop_cnt", drop_cnt, m_drops);
            if (rd_valid) begin
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL mon_head: got seq 0x%0h, expected no stored word", rd_seq);
                end else begin
                    head_exp = sb_q[0];
                    checkOutput("mon_head_data", rd_data, head_exp[31:0]);
                    checkOutput("mon_head_seq", rd_seq, head_exp[39:32]);
                    if (rd_ready && !clear) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] v;
        int         ready_pct;

        // Reset state
        #12;
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_data", rd_data, 0);
        checkOutput("rst_seq", rd_seq, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        #11 rstb = 1'b1;
        @(posedge clk_master);
        #2;

        // Constant sample 4'b1001, one cycle of latency after completion
        for (int i = 0; i < 8; i++) applyStimulus(1, 2'b10, 2'b01, 0, 0);
        checkOutput("t1_latency_valid", rd_valid, 0);
        checkOutput("t1_level", level, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_valid", rd_valid, 1);
        checkOutput("t1_data", rd_data, 32'h99999999);
        checkOutput("t1_seq", rd_seq, 0);

        // Ramp with a capture hold between samples 3 and 4
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                for (int h = 0; h < 3; h++) applyStimulus(0, 2'($urandom), 2'($urandom), 0, 0);
            end
            v = 4'(k);
            applyStimulus(1, v[3:2], v[1:0], 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_data", rd_data, 32'h76543210);
        checkOutput("t2_seq", rd_seq, 0);

        // Overflow: ten words into an eight-deep FIFO, then drain
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++) applyStimulus(1, 2'($urandom), 2'($urandom), 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3_level", level, 8);
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_drop_cnt", drop_cnt, 2);
        for (int e = 0; e < 8; e++) begin
            checkOutput("t3_drain_valid", rd_valid, 1);
            checkOutput("t3_drain_seq", rd_seq, e);
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("t3_empty_valid", rd_valid, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 2'($urandom), 2'($urandom), 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3_next_seq", rd_seq, 10);

        // Push and pop on the same edge while full
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 71; i++) applyStimulus(1, 2'($urandom), 2'($urandom), 0, 0);
        applyStimulus(1, 2'($urandom), 2'($urandom), 1, 0);
        checkOutput("t4_level", level, 8);
        checkOutput("t4_overflow", overflow, 0);
        checkOutput("t4_drop_cnt", drop_cnt, 0);
        for (int e = 1; e <= 8; e++) begin
            checkOutput("t4_drain_seq", rd_seq, e);
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("t4_level_after", level, 0);

        // Clear mid-word with three words stored and a pending pop
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 29; i++) applyStimulus(1, 2'($urandom), 2'($urandom), 0, 0);
        applyStimulus(1, 2'($urandom), 2'($urandom), 1, 1);
        checkOutput("t5_level", level, 0);
        checkOutput("t5_valid", rd_valid, 0);
        checkOutput("t5_overflow", overflow, 0);
        for (int k = 0; k < 8; k++) begin
            v = 4'(k + 1);
            applyStimulus(1, v[3:2], v[1:0], 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_seq", rd_seq, 0);
        checkOutput("t5_data", rd_data, 32'h87654321);

        // Asynchronous reset in the middle of a pop cycle
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++) applyStimulus(1, 2'($urandom), 2'($urandom), 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rd_ready = 1'b1;
        cap_en   = 1'b1;
        #2 rstb = 1'b0;
        #1;
        checkOutput("t6_valid", rd_valid, 0);
        checkOutput("t6_data", rd_data, 0);
        checkOutput("t6_seq", rd_seq, 0);
        checkOutput("t6_level", level, 0);
        checkOutput("t6_overflow", overflow, 0);
        checkOutput("t6_drop_cnt", drop_cnt, 0);
        rd_ready = 1'b0;
        cap_en   = 1'b0;
        @(posedge clk_master);
        #3 rstb = 1'b1;
        @(posedge clk_master);
        #2;
        for (int k = 0; k < 8; k++) begin
            v = 4'(k + 1);
            applyStimulus(1, v[3:2], v[1:0], 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_restart_data", rd_data, 32'h87654321);
        checkOutput("t6_restart_seq", rd_seq, 0);

        // Randomized traffic with varying reader pressure
        for (int blk = 0; blk < 20; blk++) begin
            ready_pct = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                applyStimulus($urandom_range(0, 99) < 75, 2'($urandom), 2'($urandom),
                              $urandom_range(0, 99) < ready_pct,
                              $urandom_range(0, 299) == 0);
            end
        end
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
